// File: rtl/coffee_sequencer.sv
// Coin-operated brew controller: credit accumulation, price check, timed valve
// sequence, then a timed change/refund display before returning to idle.
module coffee_sequencer #(
  parameter int TICK_DIV     = 50000000,
  parameter int STEP_TICKS   = 3,
  parameter int CHANGE_TICKS = 2,
  parameter int PRICE_COFFEE = 2,
  parameter int PRICE_MILK   = 3,
  parameter int PRICE_CAPP   = 4,
  parameter int PRICE_MOCCA  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic       cancel,
  input  logic       start,
  input  logic [2:0] c_type,
  output logic [3:0] credit,
  output logic [3:0] change,
  output logic [3:0] display,
  output logic [3:0] valve,
  output logic       busy,
  output logic       coin_reject,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WATER  = 3'd1;
  localparam logic [2:0] S_COFFEE = 3'd2;
  localparam logic [2:0] S_MILK   = 3'd3;
  localparam logic [2:0] S_CHOC   = 3'd4;
  localparam logic [2:0] S_CHANGE = 3'd5;
  localparam logic [2:0] S_REFUND = 3'd6;

  localparam int DIV_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_MAX = (2 * STEP_TICKS > CHANGE_TICKS) ? 2 * STEP_TICKS : CHANGE_TICKS;
  localparam int STEP_W  = $clog2(CNT_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [STEP_W-1:0] LONG_LAST = STEP_W'(2 * STEP_TICKS - 1);
  localparam logic [STEP_W-1:0] CHG_LAST  = STEP_W'(CHANGE_TICKS - 1);

  logic [2:0]        state, state_n;
  logic [DIV_W-1:0]  div_cnt;
  logic [STEP_W-1:0] step_cnt, step_last;
  logic [2:0]        drink, drink_n;
  logic [3:0]        credit_n, change_n, price, valve_n, display_n;
  logic [4:0]        sum;
  logic              tick, step_end, any_coin, done_n, rej_n;

  function automatic logic [3:0] price_of(input logic [2:0] c);
    case (c)
      3'd1:    price_of = 4'(PRICE_COFFEE);
      3'd2:    price_of = 4'(PRICE_MILK);
      3'd3:    price_of = 4'(PRICE_CAPP);
      3'd4:    price_of = 4'(PRICE_MOCCA);
      default: price_of = 4'd0;
    endcase
  endfunction

  assign price    = price_of(c_type);
  assign any_coin = coin_100 | coin_500;
  assign sum      = {1'b0, credit} + {4'd0, coin_100} + (coin_500 ? 5'd5 : 5'd0);
  assign tick     = (div_cnt == DIV_LAST);

  // Cappuccino holds milk for a double step; change/refund use their own length.
  always_comb begin
    step_last = STEP_LAST;
    if (state == S_MILK && drink == 3'd3)            step_last = LONG_LAST;
    else if (state == S_CHANGE || state == S_REFUND) step_last = CHG_LAST;
  end
  assign step_end = tick && (step_cnt == step_last);

  always_comb begin
    state_n  = state;
    credit_n = credit;
    change_n = change;
    drink_n  = drink;
    done_n   = 1'b0;
    rej_n    = any_coin;
    case (state)
      S_IDLE: begin
        if (cancel && credit != 4'd0) begin
          change_n = credit;
          credit_n = 4'd0;
          state_n  = S_REFUND;
        end else if (start) begin
          // Any coin arriving with start is refused; price check uses pre-coin credit.
          if (price != 4'd0 && credit >= price) begin
            drink_n  = c_type;
            change_n = credit - price;
            credit_n = 4'd0;
            state_n  = S_WATER;
          end
        end else if (sum <= 5'd15) begin
          credit_n = sum[3:0];
          rej_n    = 1'b0;
        end
      end
      S_WATER:  if (step_end) state_n = S_COFFEE;
      S_COFFEE: if (step_end) begin
        if (drink == 3'd1) begin
          state_n = S_CHANGE;
          done_n  = 1'b1;
        end else begin
          state_n = S_MILK;
        end
      end
      S_MILK: if (step_end) begin
        if (drink == 3'd4) begin
          state_n = S_CHOC;
        end else begin
          state_n = S_CHANGE;
          done_n  = 1'b1;
        end
      end
      S_CHOC: if (step_end) begin
        state_n = S_CHANGE;
        done_n  = 1'b1;
      end
      S_CHANGE, S_REFUND: if (step_end) begin
        change_n = 4'd0;
        state_n  = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_n)
      S_WATER:  valve_n = 4'b0001;
      S_COFFEE: valve_n = 4'b0010;
      S_MILK:   valve_n = 4'b0100;
      S_CHOC:   valve_n = 4'b1000;
      default:  valve_n = 4'b0000;
    endcase
  end

  always_comb begin
    case (state)
      S_IDLE:                                display_n = credit;
      S_WATER, S_COFFEE, S_MILK, S_CHOC:     display_n = {1'b0, drink};
      default:                               display_n = change;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      step_cnt    <= '0;
      drink       <= 3'd0;
      credit      <= 4'd0;
      change      <= 4'd0;
      display     <= 4'd0;
      valve       <= 4'd0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      drink       <= drink_n;
      credit      <= credit_n;
      change      <= change_n;
      display     <= display_n;
      valve       <= valve_n;
      busy        <= (state_n != S_IDLE);
      coin_reject <= rej_n;
      done        <= done_n;
      // Restart timing on every state entry so each state gets whole ticks.
      if (state_n != state) begin
        div_cnt  <= '0;
        step_cnt <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) step_cnt <= step_cnt + 1'b1;
      end
    end
  end

endmodule
